bit_serial_adder_ctrl: RTL and testbench



---
 rtl/adder_pkg.sv | 17 +
 rtl/full_adder_dataflow.sv | 15 +
 rtl/bit_serial_adder_ctrl.sv | 113 +++++++++++
 tb/tb_bit_serial_adder_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the bit-serial adder datapath.
// Holds the controller state encoding and the carry majority function.
package adder_pkg;

  localparam int MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } serial_state_t;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/full_adder_dataflow.sv
// Single-bit full-adder cell, pure dataflow.
module full_adder_dataflow
  import adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = maj3(a, b, cin);

endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// Adds two WIDTH-bit operands one bit per clock, LSB first, through one full-adder cell.
// Operands and result move through valid/ready handshakes; sum/cout hold until the next result.
module bit_serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  // The final bit is taken straight from the cell, so only WIDTH-1 bits are collected.
  localparam int SH_W = (WIDTH > 1) ? WIDTH - 1 : 1;

  serial_state_t    state_r;
  serial_state_t    state_nxt_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [SH_W-1:0]  sum_sh_r;
  logic [SH_W:0]    sum_cat_s;
  logic [CNT_W-1:0] cnt_r;
  logic             carry_r;
  logic             fa_s_s;
  logic             fa_c_s;
  logic             last_bit_s;

  full_adder_dataflow u_fa (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .cin  (carry_r),
    .s    (fa_s_s),
    .cout (fa_c_s)
  );

  assign sum_cat_s  = {fa_s_s, sum_sh_r};
  assign last_bit_s = (cnt_r == CNT_W'(WIDTH - 1));

  // Next-state decode for the IDLE/BUSY/DONE sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready) state_nxt_s = BUSY;
        else                      state_nxt_s = IDLE;
      end
      BUSY: begin
        if (last_bit_s) state_nxt_s = DONE;
        else            state_nxt_s = BUSY;
      end
      DONE: begin
        if (out_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, handshake flags, operand/sum shifters and the held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      a_sh_r    <= '0;
      b_sh_r    <= '0;
      sum_sh_r  <= '0;
      cnt_r     <= '0;
      carry_r   <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      in_ready  <= (state_nxt_s == IDLE);
      out_valid <= (state_nxt_s == DONE);
      busy      <= (state_nxt_s == BUSY);
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            carry_r <= cin;
            cnt_r   <= '0;
          end
        end
        BUSY: begin
          a_sh_r   <= a_sh_r >> 1;
          b_sh_r   <= b_sh_r >> 1;
          sum_sh_r <= sum_cat_s[SH_W:1];
          carry_r  <= fa_c_s;
          cnt_r    <= cnt_r + CNT_W'(1);
          if (last_bit_s) begin
            sum  <= sum_cat_s[SH_W -: WIDTH];
            cout <= fa_c_s;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Directed bench for bit_serial_adder_ctrl at WIDTH=8, 1 and 16.
module tb_bit_serial_adder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic rst;

  logic       iv8, ir8, ov8, or8, cin8, cout8, busy8;
  logic [7:0] a8, b8, sum8;
  logic       iv1, ir1, ov1, or1, cin1, cout1, busy1;
  logic [0:0] a1, b1, sum1;
  logic        iv16, ir16, ov16, or16, cin16, cout16, busy16;
  logic [15:0] a16, b16, sum16;

  bit_serial_adder_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8),
    .out_valid(ov8), .out_ready(or8), .sum(sum8), .cout(cout8), .busy(busy8)
  );

  bit_serial_adder_ctrl #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(cin1),
    .out_valid(ov1), .out_ready(or1), .sum(sum1), .cout(cout1), .busy(busy1)
  );

  bit_serial_adder_ctrl #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .cin(cin16),
    .out_valid(ov16), .out_ready(or16), .sum(sum16), .cout(cout16), .busy(busy16)
  );

  task automatic test_reset();
    rst = 1'b1;
    iv8 = 1'b0; or8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    iv1 = 1'b0; or1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    iv16 = 1'b0; or16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000; cin16 = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({ir8, ov8, busy8, cout8, sum8} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL reset8: got ir=%b ov=%b busy=%b cout=%b sum=%h, want 1 0 0 0 00",
               ir8, ov8, busy8, cout8, sum8);
    end
    total++;
    if ({ir1, ov1, ir16, ov16, sum16} !== {1'b1, 1'b0, 1'b1, 1'b0, 16'h0000}) begin
      bad++;
      $display("FAIL reset1_16: got ir1=%b ov1=%b ir16=%b ov16=%b sum16=%h, want 1 0 1 0 0000",
               ir1, ov1, ir16, ov16, sum16);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Entered and left on a negedge with the WIDTH=8 instance idle.
  task automatic op8(input logic [7:0] a_i, input logic [7:0] b_i, input logic c_i,
                     input logic [7:0] es, input logic ec, input string nm);
    int cyc;
    total++;
    if (ir8 !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready: got in_ready=%b, want 1", nm, ir8);
    end
    iv8 = 1'b1; a8 = a_i; b8 = b_i; cin8 = c_i;
    @(negedge clk);
    iv8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    total++;
    if (busy8 !== 1'b1 || ir8 !== 1'b0) begin
      bad++;
      $display("FAIL %s_busy: got busy=%b in_ready=%b, want 1 0", nm, busy8, ir8);
    end
    cyc = 0;
    while (ov8 !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (cyc != 8) begin
      bad++;
      $display("FAIL %s_latency: got %0d cycles, want 8", nm, cyc);
    end
    total++;
    if ({cout8, sum8} !== {ec, es}) begin
      bad++;
      $display("FAIL %s_result: got cout=%b sum=%h, want cout=%b sum=%h", nm, cout8, sum8, ec, es);
    end
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    total++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
      bad++;
      $display("FAIL %s_release: got in_ready=%b out_valid=%b, want 1 0", nm, ir8, ov8);
    end
  endtask

  task automatic test_basic();
    op8(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, "add_35_4a");
    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_01");
    op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "add_ff_ff_c");
    op8(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, "add_80_80_c");
  endtask

  task automatic test_backpressure();
    int cyc;
    iv8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    cyc = 0;
    while (ov8 !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    for (int i = 0; i < 5; i++) begin
      iv8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
      @(negedge clk);
      total++;
      if ({ov8, ir8, cout8, sum8} !== {1'b1, 1'b0, 1'b0, 8'h47}) begin
        bad++;
        $display("FAIL bp_hold%0d: got ov=%b ir=%b cout=%b sum=%h, want 1 0 0 47",
                 i, ov8, ir8, cout8, sum8);
      end
    end
    iv8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    total++;
    if ({ov8, ir8, busy8, sum8} !== {1'b0, 1'b1, 1'b0, 8'h47}) begin
      bad++;
      $display("FAIL bp_release: got ov=%b ir=%b busy=%b sum=%h, want 0 1 0 47",
               ov8, ir8, busy8, sum8);
    end
  endtask

  task automatic test_reset_mid_busy();
    bit seen;
    iv8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0;
    @(negedge clk);
    iv8 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({ir8, ov8, busy8, cout8, sum8} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL rst_busy: got ir=%b ov=%b busy=%b cout=%b sum=%h, want 1 0 0 0 00",
               ir8, ov8, busy8, cout8, sum8);
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ov8 === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL rst_no_valid: got out_valid pulse=%b, want 0", seen);
    end
    op8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "after_rst");
  endtask

  task automatic test_width1();
    logic [7:0] sum_tab;
    logic [7:0] cry_tab;
    logic [2:0] v;
    int cyc;
    sum_tab = 8'h96;
    cry_tab = 8'hE8;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      iv1 = 1'b1; a1 = v[2]; b1 = v[1]; cin1 = v[0];
      @(negedge clk);
      iv1 = 1'b0;
      cyc = 0;
      while (ov1 !== 1'b1 && cyc < 10) begin
        @(negedge clk);
        cyc++;
      end
      total++;
      if (cyc != 1 || {cout1, sum1} !== {cry_tab[i], sum_tab[i]}) begin
        bad++;
        $display("FAIL w1_case%0d: got lat=%0d cout=%b sum=%b, want lat=1 cout=%b sum=%b",
                 i, cyc, cout1, sum1, cry_tab[i], sum_tab[i]);
      end
      or1 = 1'b1;
      @(negedge clk);
      or1 = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp_q[$];
    logic [16:0] e;
    int acc, got, cyc;
    bit need_new;
    acc = 0; got = 0; cyc = 0; need_new = 1'b0;
    while (got < 1000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      or16 = ($urandom_range(0, 3) != 0);
      if (ov16 === 1'b1 && or16) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL b2b_extra: got result %h with no pending input", {cout16, sum16});
        end else begin
          e = exp_q.pop_front();
          if ({cout16, sum16} !== e) begin
            bad++;
            $display("FAIL b2b_op%0d: got %h, want %h", got, {cout16, sum16}, e);
          end
        end
        got++;
      end
      if (need_new) begin
        iv16 = 1'b0;
        need_new = 1'b0;
      end
      if (!iv16 && acc < 1000 && $urandom_range(0, 3) != 0) begin
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
        iv16 = 1'b1;
      end
      if (iv16 && ir16 === 1'b1) begin
        exp_q.push_back(17'(a16) + 17'(b16) + 17'(cin16));
        acc++;
        need_new = 1'b1;
      end
    end
    iv16 = 1'b0; or16 = 1'b0;
    total++;
    if (got != 1000 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_count: got %0d results, %0d pending, want 1000 and 0", got, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid_busy();
    test_width1();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
